// File: rtl/lr35902_snd_seq.sv
// LR35902 sound frame sequencer: divides clk to the 512 Hz step rate and owns
// the per-voice length counters, volume envelopes and NR52 active flags.
module lr35902_snd_seq #(
  parameter int STEP_DIV = 8192
) (
  input  logic        clk,
  input  logic        reset_n,
  input  logic        master_ena,
  input  logic [3:0]  trig,
  input  logic [3:0]  len_load,
  input  logic [7:0]  len_din,
  input  logic [3:0]  cntlen,
  input  logic [11:0] env_init,
  input  logic [2:0]  env_inc,
  input  logic [8:0]  env_time,
  input  logic        voc1_kill,
  output logic [3:0]  voc_active,
  output logic [11:0] env_vol,
  output logic [2:0]  step,
  output logic        len_tick,
  output logic        sweep_tick,
  output logic        env_tick
);

  localparam int DivW = $clog2(STEP_DIV);
  localparam logic [DivW-1:0] DivLast = DivW'(STEP_DIV - 1);

  logic [DivW-1:0] div_q, div_d;
  logic [2:0]      step_q, step_d;
  logic [3:0]      act_q, act_d;
  logic [7:0]      len_q [4];
  logic [7:0]      len_d [4];
  logic [3:0]      vol_q [3];
  logic [3:0]      vol_d [3];
  logic [2:0]      per_q [3];
  logic [2:0]      per_d [3];
  logic            tick;
  logic [3:0]      dacGate;

  // Voice 3 uses the full 8-bit length; the others are 6-bit.
  function automatic logic [7:0] lenMax(input int v);
    return (v == 2) ? 8'hFF : 8'h3F;
  endfunction

  // Envelope slot k drives voices 1, 2 and 4 (indices 0, 1, 3).
  function automatic int envVoice(input int k);
    return (k == 2) ? 3 : k;
  endfunction

  assign tick       = (div_q == DivLast);
  assign len_tick   = tick & ~step_q[0];
  assign sweep_tick = tick & ((step_q == 3'd2) | (step_q == 3'd6));
  assign env_tick   = tick & (step_q == 3'd7);

  assign dacGate = {(|env_init[11:8]) | env_inc[2],
                    1'b1,
                    (|env_init[7:4]) | env_inc[1],
                    (|env_init[3:0]) | env_inc[0]};

  assign voc_active = act_q;
  assign step       = step_q;
  assign env_vol    = {vol_q[2], vol_q[1], vol_q[0]};

  // Divider, length counters and active flags; trigger beats a wrap, kill and
  // a closed DAC gate beat the trigger.
  always_comb begin
    div_d  = tick ? '0 : div_q + DivW'(1);
    step_d = step_q + {2'b00, tick};
    act_d  = act_q;
    for (int i = 0; i < 4; i++) begin
      len_d[i] = len_q[i];
      if (len_load[i]) begin
        len_d[i] = len_din & lenMax(i);
      end else if (len_tick && cntlen[i] && act_q[i]) begin
        if (len_q[i] == lenMax(i)) begin
          len_d[i] = 8'd0;
          act_d[i] = 1'b0;
        end else begin
          len_d[i] = len_q[i] + 8'd1;
        end
      end
      if (trig[i]) act_d[i] = 1'b1;
      if (!dacGate[i]) act_d[i] = 1'b0;
    end
    if (voc1_kill) act_d[0] = 1'b0;
  end

  // Envelopes step only on expiry of their period and saturate at 0 and 15.
  always_comb begin
    for (int k = 0; k < 3; k++) begin
      vol_d[k] = vol_q[k];
      per_d[k] = per_q[k];
      if (trig[envVoice(k)]) begin
        vol_d[k] = env_init[4*k +: 4];
        per_d[k] = env_time[3*k +: 3];
      end else if (env_tick && (env_time[3*k +: 3] != 3'd0) && act_q[envVoice(k)]) begin
        if (per_q[k] <= 3'd1) begin
          per_d[k] = env_time[3*k +: 3];
          if (env_inc[k]) begin
            if (vol_q[k] != 4'hF) vol_d[k] = vol_q[k] + 4'd1;
          end else if (vol_q[k] != 4'h0) begin
            vol_d[k] = vol_q[k] - 4'd1;
          end
        end else begin
          per_d[k] = per_q[k] - 3'd1;
        end
      end
    end
  end

  always_ff @(posedge clk) begin
    if (!reset_n || !master_ena) begin
      div_q  <= '0;
      step_q <= '0;
      act_q  <= '0;
      for (int i = 0; i < 4; i++) len_q[i] <= '0;
      for (int k = 0; k < 3; k++) begin
        vol_q[k] <= '0;
        per_q[k] <= '0;
      end
    end else begin
      div_q  <= div_d;
      step_q <= step_d;
      act_q  <= act_d;
      for (int i = 0; i < 4; i++) len_q[i] <= len_d[i];
      for (int k = 0; k < 3; k++) begin
        vol_q[k] <= vol_d[k];
        per_q[k] <= per_d[k];
      end
    end
  end

endmodule

// File: tb/tb_lr35902_snd_seq.sv
// Self-checking bench for lr35902_snd_seq: directed scenarios plus a random
// run, all compared against a behavioural model of the sequencer.
module tb_lr35902_snd_seq;

  localparam int SD = 4;

  logic        clk = 1'b0;
  logic        reset_n;
  logic        master_ena;
  logic [3:0]  trig;
  logic [3:0]  len_load;
  logic [7:0]  len_din;
  logic [3:0]  cntlen;
  logic [11:0] env_init;
  logic [2:0]  env_inc;
  logic [8:0]  env_time;
  logic        voc1_kill;
  logic [3:0]  voc_active;
  logic [11:0] env_vol;
  logic [2:0]  step;
  logic        len_tick;
  logic        sweep_tick;
  logic        env_tick;

  int checks = 0;
  int errors = 0;

  // Model state: cycles since enable, length counts, flags, envelopes.
  int       mCyc;
  int       mLen [4];
  bit [3:0] mAct;
  int       mVol [3];
  int       mPer [3];

  always #5 clk = ~clk;

  lr35902_snd_seq #(.STEP_DIV(SD)) dut (
    .clk(clk), .reset_n(reset_n), .master_ena(master_ena),
    .trig(trig), .len_load(len_load), .len_din(len_din), .cntlen(cntlen),
    .env_init(env_init), .env_inc(env_inc), .env_time(env_time),
    .voc1_kill(voc1_kill), .voc_active(voc_active), .env_vol(env_vol),
    .step(step), .len_tick(len_tick), .sweep_tick(sweep_tick), .env_tick(env_tick)
  );

  function automatic bit mTick();
    return (mCyc % SD) == SD - 1;
  endfunction

  function automatic int mStep();
    return (mCyc / SD) % 8;
  endfunction

  function automatic bit mLenTick();
    return mTick() && (mStep() % 2 == 0);
  endfunction

  function automatic bit mSweepTick();
    return mTick() && (mStep() == 2 || mStep() == 6);
  endfunction

  function automatic bit mEnvTick();
    return mTick() && (mStep() == 7);
  endfunction

  function automatic bit mGate(int v);
    int k;
    if (v == 2) return 1'b1;
    k = (v == 3) ? 2 : v;
    return (env_init[4*k +: 4] != 4'd0) || env_inc[k];
  endfunction

  function automatic logic [11:0] mVolVec();
    return {4'(mVol[2]), 4'(mVol[1]), 4'(mVol[0])};
  endfunction

  // One clock edge of the reference behaviour, using the inputs seen at that edge.
  function automatic void modelStep();
    bit [3:0] newAct;
    bit lt, et;
    int lim, v, tm;
    if (!reset_n || !master_ena) begin
      mCyc = 0;
      mAct = '0;
      for (int i = 0; i < 4; i++) mLen[i] = 0;
      for (int k = 0; k < 3; k++) begin mVol[k] = 0; mPer[k] = 0; end
    end else begin
      lt = mLenTick();
      et = mEnvTick();
      newAct = mAct;
      for (int i = 0; i < 4; i++) begin
        lim = (i == 2) ? 256 : 64;
        if (len_load[i]) begin
          mLen[i] = int'(len_din) % lim;
        end else if (lt && cntlen[i] && mAct[i]) begin
          mLen[i] = (mLen[i] + 1) % lim;
          if (mLen[i] == 0) newAct[i] = 1'b0;
        end
        if (trig[i]) newAct[i] = 1'b1;
        if (i == 0 && voc1_kill) newAct[i] = 1'b0;
        if (!mGate(i)) newAct[i] = 1'b0;
      end
      for (int k = 0; k < 3; k++) begin
        v  = (k == 2) ? 3 : k;
        tm = int'(env_time[3*k +: 3]);
        if (trig[v]) begin
          mVol[k] = int'(env_init[4*k +: 4]);
          mPer[k] = tm;
        end else if (et && tm != 0 && mAct[v]) begin
          if (mPer[k] <= 1) begin
            mPer[k] = tm;
            if (env_inc[k]) mVol[k] = (mVol[k] >= 15) ? 15 : mVol[k] + 1;
            else            mVol[k] = (mVol[k] <= 0) ? 0 : mVol[k] - 1;
          end else begin
            mPer[k] = mPer[k] - 1;
          end
        end
      end
      mAct = newAct;
      mCyc++;
    end
  endfunction

  task automatic cycle();
    @(posedge clk);
    modelStep();
    @(negedge clk);
  endtask

  task automatic test_reset();
    reset_n = 1'b0;
    master_ena = 1'b1;
    for (int i = 0; i < 4; i++) begin
      trig = 4'($urandom);
      len_load = 4'($urandom);
      len_din = 8'($urandom);
      env_init = 12'($urandom);
      cycle();
    end
    trig = '0; len_load = '0; env_init = '0;
    checks++;
    if (voc_active !== 4'h0) begin errors++; $display("[TB] FAIL reset_active: got %h expected 0", voc_active); end
    checks++;
    if (env_vol !== 12'h000) begin errors++; $display("[TB] FAIL reset_env_vol: got %h expected 000", env_vol); end
    checks++;
    if (step !== 3'd0) begin errors++; $display("[TB] FAIL reset_step: got %0d expected 0", step); end
    checks++;
    if ({len_tick, sweep_tick, env_tick} !== 3'b000)
      begin errors++; $display("[TB] FAIL reset_strobes: got %b expected 000", {len_tick, sweep_tick, env_tick}); end
  endtask

  task automatic test_sequencer();
    int nLen, nSweep, nEnv;
    logic pl, ps, pe;
    nLen = 0; nSweep = 0; nEnv = 0;
    pl = 1'b0; ps = 1'b0; pe = 1'b0;
    reset_n = 1'b1;
    for (int c = 0; c < 64; c++) begin
      cycle();
      checks++;
      if (step !== 3'(mStep())) begin errors++; $display("[TB] FAIL seq_step: got %0d expected %0d", step, mStep()); end
      checks++;
      if ({len_tick, sweep_tick, env_tick} !== {mLenTick(), mSweepTick(), mEnvTick()})
        begin errors++; $display("[TB] FAIL seq_strobes: got %b expected %b", {len_tick, sweep_tick, env_tick}, {mLenTick(), mSweepTick(), mEnvTick()}); end
      checks++;
      if ((len_tick && pl) || (sweep_tick && ps) || (env_tick && pe))
        begin errors++; $display("[TB] FAIL seq_width: strobe high two cycles got %b expected single", {len_tick, sweep_tick, env_tick}); end
      if (len_tick === 1'b1) nLen++;
      if (sweep_tick === 1'b1) nSweep++;
      if (env_tick === 1'b1) nEnv++;
      pl = len_tick; ps = sweep_tick; pe = env_tick;
    end
    checks++;
    if (nLen != 8 || nSweep != 4 || nEnv != 2)
      begin errors++; $display("[TB] FAIL seq_counts: got %0d/%0d/%0d expected 8/4/2", nLen, nSweep, nEnv); end
    checks++;
    if (step !== 3'd0) begin errors++; $display("[TB] FAIL seq_wrap: got %0d expected 0", step); end
  endtask

  task automatic test_length_v2();
    int dins [2];
    int expT [2];
    int n, cnt;
    dins = '{62, 0};
    expT = '{2, 64};
    env_init = 12'h080; env_inc = '0; env_time = '0; cntlen = 4'b0010;
    for (int c = 0; c < 2; c++) begin
      len_din = 8'(dins[c]); len_load = 4'b0010; trig = 4'b0010;
      cycle();
      len_load = '0; trig = '0;
      checks++;
      if (voc_active[1] !== 1'b1) begin errors++; $display("[TB] FAIL v2_trig: got %b expected 1", voc_active[1]); end
      n = 0; cnt = 0;
      while (voc_active[1] === 1'b1 && n < 1200) begin
        if (len_tick === 1'b1) cnt++;
        checks++;
        if (voc_active !== mAct) begin errors++; $display("[TB] FAIL v2_active: got %h expected %h", voc_active, mAct); end
        cycle();
        n++;
      end
      checks++;
      if (n >= 1200) begin errors++; $display("[TB] FAIL v2_timeout: got %0d cycles expected expiry", n); end
      checks++;
      if (cnt != expT[c]) begin errors++; $display("[TB] FAIL v2_len_ticks: got %0d expected %0d", cnt, expT[c]); end
    end
  endtask

  task automatic test_length_v3();
    int n, cnt;
    bit stayed;
    cntlen = 4'b0100; len_din = 8'hFF; len_load = 4'b0100; trig = 4'b0100;
    cycle();
    len_load = '0; trig = '0;
    n = 0; cnt = 0;
    while (voc_active[2] === 1'b1 && n < 200) begin
      if (len_tick === 1'b1) cnt++;
      cycle();
      n++;
    end
    checks++;
    if (cnt != 1 || n >= 200) begin errors++; $display("[TB] FAIL v3_len_ticks: got %0d expected 1", cnt); end
    cntlen = 4'b0000; len_din = 8'hF0; len_load = 4'b0100; trig = 4'b0100;
    cycle();
    len_load = '0; trig = '0;
    stayed = 1'b1;
    for (int c = 0; c < 300; c++) begin
      if (voc_active[2] !== 1'b1) stayed = 1'b0;
      checks++;
      if (voc_active !== mAct) begin errors++; $display("[TB] FAIL v3_model: got %h expected %h", voc_active, mAct); end
      cycle();
    end
    checks++;
    if (!stayed) begin errors++; $display("[TB] FAIL v3_hold: got inactive expected active"); end
  endtask

  task automatic test_envelope();
    int expV4 [3];
    int expV1 [3];
    int n;
    expV4 = '{1, 0, 0};
    expV1 = '{14, 15, 15};
    cntlen = '0;
    env_init = 12'h200; env_inc = 3'b000; env_time = 9'b001_000_000;
    trig = 4'b1000;
    cycle();
    trig = '0;
    for (int j = 0; j < 3; j++) begin
      n = 0;
      while (env_tick !== 1'b1 && n < 200) begin cycle(); n++; end
      checks++;
      if (n >= 200) begin errors++; $display("[TB] FAIL env_v4_timeout: got no env_tick expected one"); end
      cycle();
      checks++;
      if (env_vol[11:8] !== 4'(expV4[j])) begin errors++; $display("[TB] FAIL env_v4_vol: got %0d expected %0d", env_vol[11:8], expV4[j]); end
    end
    env_init = 12'h20E; env_inc = 3'b001; env_time = 9'b001_000_010;
    trig = 4'b0001;
    cycle();
    trig = '0;
    for (int j = 0; j < 3; j++) begin
      n = 0;
      while (env_tick !== 1'b1 && n < 200) begin cycle(); n++; end
      checks++;
      if (n >= 200) begin errors++; $display("[TB] FAIL env_v1_timeout: got no env_tick expected one"); end
      cycle();
      checks++;
      if (env_vol[3:0] !== 4'(expV1[j])) begin errors++; $display("[TB] FAIL env_v1_vol: got %0d expected %0d", env_vol[3:0], expV1[j]); end
      checks++;
      if (env_vol !== mVolVec()) begin errors++; $display("[TB] FAIL env_model: got %h expected %h", env_vol, mVolVec()); end
    end
  endtask

  task automatic test_gate_kill();
    env_init = 12'h200; env_inc = 3'b000;
    cycle();
    checks++;
    if (voc_active[0] !== 1'b0) begin errors++; $display("[TB] FAIL gate_close: got %b expected 0", voc_active[0]); end
    trig = 4'b0001;
    cycle();
    trig = '0;
    checks++;
    if (voc_active[0] !== 1'b0) begin errors++; $display("[TB] FAIL gate_trig: got %b expected 0", voc_active[0]); end
    env_init = 12'h205; trig = 4'b0001; voc1_kill = 1'b1;
    cycle();
    trig = '0; voc1_kill = 1'b0;
    checks++;
    if (voc_active[0] !== 1'b0) begin errors++; $display("[TB] FAIL kill_vs_trig: got %b expected 0", voc_active[0]); end
    trig = 4'b0001;
    cycle();
    trig = '0;
    checks++;
    if (voc_active[0] !== 1'b1) begin errors++; $display("[TB] FAIL gate_open_trig: got %b expected 1", voc_active[0]); end
    voc1_kill = 1'b1;
    cycle();
    voc1_kill = 1'b0;
    checks++;
    if (voc_active[0] !== 1'b0) begin errors++; $display("[TB] FAIL kill: got %b expected 0", voc_active[0]); end
  endtask

  task automatic test_master_off();
    int n;
    env_init = 12'h555; env_inc = 3'b000; env_time = '0; cntlen = '0;
    trig = 4'hF;
    cycle();
    trig = '0;
    checks++;
    if (voc_active !== 4'hF) begin errors++; $display("[TB] FAIL mo_all_active: got %h expected F", voc_active); end
    checks++;
    if (env_vol !== 12'h555) begin errors++; $display("[TB] FAIL mo_env_load: got %h expected 555", env_vol); end
    repeat (5) cycle();
    master_ena = 1'b0; trig = 4'hF;
    cycle();
    master_ena = 1'b1; trig = '0;
    checks++;
    if (voc_active !== 4'h0 || env_vol !== 12'h000 || step !== 3'd0)
      begin errors++; $display("[TB] FAIL mo_clear: got %h/%h/%0d expected 0/000/0", voc_active, env_vol, step); end
    // The divider restarts at 0, so the first tick is its fourth cycle.
    n = 0;
    while (len_tick !== 1'b1 && n < 20) begin cycle(); n++; end
    checks++;
    if (n != SD - 1) begin errors++; $display("[TB] FAIL mo_first_tick: got %0d edges expected %0d", n, SD - 1); end
    checks++;
    if (voc_active !== 4'h0) begin errors++; $display("[TB] FAIL mo_trig_ignored: got %h expected 0", voc_active); end
  endtask

  task automatic test_random();
    for (int c = 0; c < 3000; c++) begin
      for (int i = 0; i < 4; i++) begin
        trig[i] = ($urandom_range(0, 31) == 0);
        len_load[i] = ($urandom_range(0, 63) == 0);
      end
      len_din = 8'($urandom);
      if ($urandom_range(0, 31) == 0) cntlen = 4'($urandom);
      if ($urandom_range(0, 63) == 0) begin
        env_init = 12'($urandom);
        env_inc = 3'($urandom);
        env_time = 9'($urandom);
      end
      voc1_kill = ($urandom_range(0, 63) == 0);
      master_ena = ($urandom_range(0, 299) != 0);
      reset_n = ($urandom_range(0, 499) != 0);
      cycle();
      checks++;
      if (voc_active !== mAct) begin errors++; $display("[TB] FAIL rnd_active: got %h expected %h", voc_active, mAct); end
      checks++;
      if (env_vol !== mVolVec()) begin errors++; $display("[TB] FAIL rnd_env_vol: got %h expected %h", env_vol, mVolVec()); end
      checks++;
      if (step !== 3'(mStep())) begin errors++; $display("[TB] FAIL rnd_step: got %0d expected %0d", step, mStep()); end
      checks++;
      if ({len_tick, sweep_tick, env_tick} !== {mLenTick(), mSweepTick(), mEnvTick()})
        begin errors++; $display("[TB] FAIL rnd_strobes: got %b expected %b", {len_tick, sweep_tick, env_tick}, {mLenTick(), mSweepTick(), mEnvTick()}); end
    end
    trig = '0; len_load = '0; voc1_kill = 1'b0; master_ena = 1'b1; reset_n = 1'b1;
  endtask

  initial begin
    reset_n = 1'b0; master_ena = 1'b1; trig = '0; len_load = '0; len_din = '0;
    cntlen = '0; env_init = '0; env_inc = '0; env_time = '0; voc1_kill = 1'b0;
    mCyc = 0; mAct = '0;
    for (int i = 0; i < 4; i++) mLen[i] = 0;
    for (int k = 0; k < 3; k++) begin mVol[k] = 0; mPer[k] = 0; end
    test_reset();
    test_sequencer();
    test_length_v2();
    test_length_v3();
    test_envelope();
    test_gate_kill();
    test_master_off();
    test_random();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
